// File: rtl/dual_update.sv
// rtl/dual_update.sv - ADMM dual update y+x-v / g+u-z through one shared saturating adder
// Optional DUAL_RESIDUAL_EN adds primal_res, the running max of |x-v| and |u-z|.
module dual_update #(
    parameter int STATE_DIM   = 12,
    parameter int CONTROL_DIM = 4,
    parameter int W           = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [STATE_DIM*W-1:0]   x_k,
    input  logic [STATE_DIM*W-1:0]   v_k,
    input  logic [STATE_DIM*W-1:0]   y_k,
    input  logic [CONTROL_DIM*W-1:0] u_k,
    input  logic [CONTROL_DIM*W-1:0] z_k,
    input  logic [CONTROL_DIM*W-1:0] g_k,
    output logic [STATE_DIM*W-1:0]   y_next,
    output logic [CONTROL_DIM*W-1:0] g_next,
    output logic                     busy,
`ifdef DUAL_RESIDUAL_EN
    output logic                     done,
    output logic [W-1:0]             primal_res
`else
    output logic                     done
`endif
);
    localparam int MAXD = (STATE_DIM > CONTROL_DIM) ? STATE_DIM : CONTROL_DIM;
    localparam int IW   = (MAXD > 1) ? $clog2(MAXD) : 1;
    localparam int SW   = W + 2;
    localparam logic [IW-1:0]        SLAST = IW'(STATE_DIM - 1);
    localparam logic [IW-1:0]        CLAST = IW'(CONTROL_DIM - 1);
    localparam logic signed [SW-1:0] SMAX  = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [SW-1:0] SMIN  = {3'b111, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, STATE, CTRL, DONE} state_t;

    state_t                   state;
    logic [IW-1:0]            idx;
    logic [STATE_DIM*W-1:0]   xs, vs, ys;
    logic [CONTROL_DIM*W-1:0] us, zs, gs;

    int                       base;
    logic [W-1:0]             opa, opb, opc;
    logic signed [SW-1:0]     sum;
    logic [W-1:0]             sat_val;

    // The operand mux follows the FSM phase; the same adder serves both vectors.
    always_comb begin
        base = int'(idx) * W;
        if (state == CTRL) begin
            opa = gs[base +: W];
            opb = us[base +: W];
            opc = zs[base +: W];
        end else begin
            opa = ys[base +: W];
            opb = xs[base +: W];
            opc = vs[base +: W];
        end
        sum = {{2{opa[W-1]}}, opa} + {{2{opb[W-1]}}, opb} - {{2{opc[W-1]}}, opc};
        if (sum > SMAX)
            sat_val = SMAX[W-1:0];
        else if (sum < SMIN)
            sat_val = SMIN[W-1:0];
        else
            sat_val = sum[W-1:0];
    end

`ifdef DUAL_RESIDUAL_EN
    localparam logic [W:0] MAGMAX = {2'b00, {(W-1){1'b1}}};
    logic signed [W:0] diff;
    logic [W:0]        mag;
    logic [W-1:0]      mag_sat;

    always_comb begin
        diff    = {opb[W-1], opb} - {opc[W-1], opc};
        mag     = diff[W] ? -diff : diff;
        mag_sat = (mag > MAGMAX) ? MAGMAX[W-1:0] : mag[W-1:0];
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            idx    <= '0;
            xs     <= '0;
            vs     <= '0;
            ys     <= '0;
            us     <= '0;
            zs     <= '0;
            gs     <= '0;
            y_next <= '0;
            g_next <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
`ifdef DUAL_RESIDUAL_EN
            primal_res <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        xs    <= x_k;
                        vs    <= v_k;
                        ys    <= y_k;
                        us    <= u_k;
                        zs    <= z_k;
                        gs    <= g_k;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= STATE;
`ifdef DUAL_RESIDUAL_EN
                        primal_res <= '0;
`endif
                    end
                end
                STATE: begin
                    y_next[base +: W] <= sat_val;
`ifdef DUAL_RESIDUAL_EN
                    if (mag_sat > primal_res) primal_res <= mag_sat;
`endif
                    if (idx == SLAST) begin
                        idx   <= '0;
                        state <= CTRL;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                CTRL: begin
                    g_next[base +: W] <= sat_val;
`ifdef DUAL_RESIDUAL_EN
                    if (mag_sat > primal_res) primal_res <= mag_sat;
`endif
                    if (idx == CLAST) begin
                        idx   <= '0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dual_update.sv
// tb/tb_dual_update.sv - table-driven, scoreboarded bench for dual_update
module tb_dual_update;
    localparam int S = 12;
    localparam int C = 4;
    localparam int W = 16;

    typedef struct {
        logic [S*W-1:0] x, v, y, ey;
        logic [C*W-1:0] u, z, g, eg;
        logic [W-1:0]   eres;
    } vec_t;

    typedef struct {
        logic [S*W-1:0] ey;
        logic [C*W-1:0] eg;
        logic [W-1:0]   eres;
    } exp_t;

    logic           clk, reset, start;
    logic [S*W-1:0] x_k, v_k, y_k, y_next;
    logic [C*W-1:0] u_k, z_k, g_k, g_next;
    logic           busy, done;
`ifdef DUAL_RESIDUAL_EN
    logic [W-1:0]   primal_res;
`endif

    dual_update #(.STATE_DIM(S), .CONTROL_DIM(C), .W(W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .x_k(x_k), .v_k(v_k), .y_k(y_k),
        .u_k(u_k), .z_k(z_k), .g_k(g_k),
        .y_next(y_next), .g_next(g_next),
        .busy(busy),
`ifdef DUAL_RESIDUAL_EN
        .done(done),
        .primal_res(primal_res)
`else
        .done(done)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    vec_t tbl [6];
    exp_t sb [$];
    int   total = 0, passed = 0, done_count = 0, cyc = 0, last_done = -1;
    bit   b2b = 1'b0, prev_done = 1'b0;

    task automatic chk(input bit ok, input string name, input string detail);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: %s", name, detail);
    endtask

    function automatic int sat(input int a);
        if (a > 32767) return 32767;
        if (a < -32768) return -32768;
        return a;
    endfunction

    function automatic vec_t model(input vec_t t);
        int mx, d, a, b, c;
        mx = 0;
        for (int i = 0; i < S; i++) begin
            a = int'($signed(t.y[i*W +: W]));
            b = int'($signed(t.x[i*W +: W]));
            c = int'($signed(t.v[i*W +: W]));
            t.ey[i*W +: W] = 16'(sat(a + b - c));
            d = (b - c < 0) ? c - b : b - c;
            if (d > 32767) d = 32767;
            if (d > mx) mx = d;
        end
        for (int i = 0; i < C; i++) begin
            a = int'($signed(t.g[i*W +: W]));
            b = int'($signed(t.u[i*W +: W]));
            c = int'($signed(t.z[i*W +: W]));
            t.eg[i*W +: W] = 16'(sat(a + b - c));
            d = (b - c < 0) ? c - b : b - c;
            if (d > 32767) d = 32767;
            if (d > mx) mx = d;
        end
        t.eres = 16'(mx);
        return t;
    endfunction

    task automatic drive(input vec_t t);
        x_k = t.x; v_k = t.v; y_k = t.y;
        u_k = t.u; z_k = t.z; g_k = t.g;
    endtask

    task automatic push(input vec_t t);
        exp_t e;
        e.ey = t.ey; e.eg = t.eg; e.eres = t.eres;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one job; disturb zeroes all inputs and re-pulses start mid-job.
    task automatic run_job(input vec_t t, input bit disturb);
        int n;
        bit busy_ok;
        drive(t);
        push(t);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        busy_ok = 1'b1;
        while (!done && n < 40) begin
            if (!busy) busy_ok = 1'b0;
            if (disturb && n == 3) begin
                x_k = '0; v_k = '0; y_k = '0; u_k = '0; z_k = '0; g_k = '0;
                start = 1'b1;
            end
            if (disturb && n == 4) start = 1'b0;
            tick();
            n++;
        end
        chk(n == 16, "latency", $sformatf("done after %0d edges, want 16", n));
        chk(busy_ok && busy, "busy", $sformatf("busy dropped=%0b busy_at_done=%0b, want 0/1", !busy_ok, busy));
        tick();
    endtask

    initial begin
        exp_t e;
        int   n0, n;

        reset = 1'b1; start = 1'b0;
        x_k = '0; v_k = '0; y_k = '0; u_k = '0; z_k = '0; g_k = '0;

        for (int k = 0; k < 6; k++) begin
            tbl[k].x = '0; tbl[k].v = '0; tbl[k].y = '0; tbl[k].ey = '0;
            tbl[k].u = '0; tbl[k].z = '0; tbl[k].g = '0; tbl[k].eg = '0;
            tbl[k].eres = '0;
        end
        for (int i = 0; i < S; i++) begin
            tbl[0].x[i*W +: W]  = 16'(i + 1);
            tbl[0].v[i*W +: W]  = 16'(10);
            tbl[0].y[i*W +: W]  = 16'(12 - i);
            tbl[0].ey[i*W +: W] = 16'(3);
        end
        for (int i = 0; i < C; i++) begin
            tbl[0].u[i*W +: W]  = 16'(i + 1);
            tbl[0].z[i*W +: W]  = 16'(5);
            tbl[0].g[i*W +: W]  = 16'(6 - i);
            tbl[0].eg[i*W +: W] = 16'(2);
        end
        tbl[0].eres = 16'(9);
        tbl[1].y[15:0]  = 16'h7FFF; tbl[1].x[15:0]  = 16'd100;     tbl[1].v[15:0]  = 16'd0;
        tbl[1].y[31:16] = 16'h8000; tbl[1].x[31:16] = 16'hFFFB;    tbl[1].v[31:16] = 16'd10;
        tbl[1].g[15:0]  = 16'd32000; tbl[1].u[15:0] = 16'd1000;    tbl[1].z[15:0]  = 16'hFC18;
        tbl[1].ey[15:0] = 16'h7FFF; tbl[1].ey[31:16] = 16'h8000;   tbl[1].eg[15:0] = 16'h7FFF;
        tbl[1].eres = 16'd2000;
        tbl[2] = tbl[0];
        tbl[2].x[11*W +: W]  = 16'hFFEC;
        tbl[2].ey[11*W +: W] = 16'hFFE3;
        tbl[2].eres = 16'd30;
        for (int k = 3; k < 6; k++) begin
            for (int i = 0; i < S; i++) begin
                tbl[k].x[i*W +: W] = 16'($urandom);
                tbl[k].v[i*W +: W] = 16'($urandom);
                tbl[k].y[i*W +: W] = 16'($urandom);
            end
            for (int i = 0; i < C; i++) begin
                tbl[k].u[i*W +: W] = 16'($urandom);
                tbl[k].z[i*W +: W] = 16'($urandom);
                tbl[k].g[i*W +: W] = 16'($urandom);
            end
            tbl[k] = model(tbl[k]);
        end

        fork
            forever begin
                @(negedge clk);
                cyc++;
                if (done) begin
                    chk(!prev_done, "done_single", "done high on consecutive cycles");
                    if (sb.size() == 0) begin
                        chk(1'b0, "unexpected_done", "done with empty scoreboard");
                    end else begin
                        e = sb.pop_front();
                        chk(y_next == e.ey, "y_next", $sformatf("got %h want %h", y_next, e.ey));
                        chk(g_next == e.eg, "g_next", $sformatf("got %h want %h", g_next, e.eg));
`ifdef DUAL_RESIDUAL_EN
                        chk(primal_res == e.eres, "primal_res", $sformatf("got %0d want %0d", primal_res, e.eres));
`endif
                    end
                    if (b2b && last_done >= 0)
                        chk(cyc - last_done == 18, "b2b_period", $sformatf("got %0d want 18", cyc - last_done));
                    last_done = cyc;
                    done_count++;
                end
                prev_done = done;
            end
        join_none

        #3 reset = 1'b0;
        repeat (3) tick();
        chk(y_next == '0 && g_next == '0, "reset_outputs", $sformatf("y %h g %h want 0", y_next, g_next));
        chk(!busy && !done, "reset_flags", $sformatf("busy %0b done %0b want 0 0", busy, done));
`ifdef DUAL_RESIDUAL_EN
        chk(primal_res == '0, "reset_res", $sformatf("got %0d want 0", primal_res));
`endif
        reset = 1'b1;
        tick();

        for (int k = 0; k < 6; k++) run_job(tbl[k], 1'b0);

        n0 = done_count;
        run_job(tbl[2], 1'b1);
        repeat (25) tick();
        chk(done_count == n0 + 1, "snapshot_one_done", $sformatf("got %0d done pulses want 1", done_count - n0));

        drive(tbl[1]);
        push(tbl[1]);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        reset = 1'b0;
        #1;
        chk(y_next == '0 && g_next == '0, "abort_outputs", $sformatf("y %h g %h want 0", y_next, g_next));
        chk(!busy && !done, "abort_flags", $sformatf("busy %0b done %0b want 0 0", busy, done));
        sb.delete();
        n0 = done_count;
        repeat (3) tick();
        reset = 1'b1;
        repeat (20) tick();
        chk(done_count == n0 && !busy, "abort_no_done", $sformatf("dones %0d busy %0b want 0 0", done_count - n0, busy));
        run_job(tbl[3], 1'b0);

        b2b = 1'b1;
        last_done = -1;
        n0 = done_count;
        drive(tbl[0]);
        repeat (3) push(tbl[0]);
        start = 1'b1;
        n = 0;
        while (done_count < n0 + 3 && n < 200) begin
            tick();
            n++;
        end
        start = 1'b0;
        chk(done_count == n0 + 3, "b2b_jobs", $sformatf("got %0d jobs want 3", done_count - n0));
        repeat (30) tick();
        b2b = 1'b0;
        chk(!busy, "b2b_idle", $sformatf("busy %0b want 0", busy));
        chk(sb.size() == 0, "scoreboard_empty", $sformatf("%0d entries left want 0", sb.size()));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/dual_update.md
Name: dual_update

Overview:
- ADMM dual-variable update stage. Sits directly downstream of the slack update stage in the MPC solver loop.
- Consumes the projected slacks v_k (state) and z_k (control) together with the primal iterates x_k and u_k and the current duals y_k and g_k.
- Produces the next duals y_next = y_k + x_k - v_k and g_next = g_k + u_k - z_k.
- Serial datapath: one element per cycle through a single shared saturating adder, sequenced by an FSM.

Parameters:
- STATE_DIM, 12, number of state elements (x, v, y)
- CONTROL_DIM, 4, number of control elements (u, z, g)
- W, 16, signed fixed-point word width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- x_k  in  W x STATE_DIM  primal state iterate, signed
- v_k  in  W x STATE_DIM  state slack from slack update, signed
- y_k  in  W x STATE_DIM  current state dual, signed
- u_k  in  W x CONTROL_DIM  primal control iterate, signed
- z_k  in  W x CONTROL_DIM  control slack from slack update, signed
- g_k  in  W x CONTROL_DIM  current control dual, signed
- y_next  out  W x STATE_DIM  updated state dual
- g_next  out  W x CONTROL_DIM  updated control dual
- busy  out  1  high from the cycle after start is accepted until done is deasserted
- done  out  1  one-cycle pulse; all results valid and held

Behaviour:
- Reset (reset=0, asynchronous): FSM goes to IDLE; index counter = 0; y_next, g_next, busy, done all 0.
- FSM states: IDLE, STATE, CTRL, DONE.
- IDLE:
  - On a clk edge with start=1, capture all six input arrays into internal snapshot registers.
  - Set idx=0 and go to STATE.
  - Inputs may change freely after the capture edge.
- STATE: each edge writes y_next[idx] = sat(y[idx] + x[idx] - v[idx]) and increments idx. On the edge writing idx=STATE_DIM-1, set idx=0 and go to CTRL.
- CTRL: each edge writes g_next[idx] = sat(g[idx] + u[idx] - z[idx]). On the edge writing idx=CONTROL_DIM-1, go to DONE.
- DONE: done=1 for exactly one cycle; the next edge returns to IDLE.
- Latency: done is high in the cycle following edge N = STATE_DIM+CONTROL_DIM after the start-capture edge (edge 0). For the defaults, done goes high after edge 16.
- busy = (state != IDLE).
- start while not in IDLE is ignored. No queuing; the current job is unaffected.
- start high in the DONE cycle is ignored. A start on the following IDLE cycle is accepted, so back-to-back jobs have a 1-cycle gap.
- Outputs hold their last values between jobs. Elements not yet rewritten keep their previous-job values until overwritten.
- Arithmetic:
  - Sign-extend operands to W+2 bits and compute a + b - c exactly.
  - Saturate to [-2^(W-1), 2^(W-1)-1]. No wrap-around under any input.
- Reset asserted mid-job: job aborted, all outputs cleared, no done pulse. After release, the FSM waits in IDLE for a new start.
- STATE_DIM >= 1 and CONTROL_DIM >= 1 are required. The index counter is wide enough for max(STATE_DIM, CONTROL_DIM).

Optional Feature:
- Macro DUAL_RESIDUAL_EN.
- Defined:
  - Adds output port primal_res (out, W, unsigned magnitude) = max over all elements of |x-v| and |u-z|, each saturated to 2^(W-1)-1.
  - Computed incrementally with a running-max register: cleared on start capture, updated each STATE/CTRL cycle.
  - Register value is updated and held across jobs like y_next. The port value is valid (final maximum) while done=1.
  - Reset value 0.
- Undefined: port and running-max logic absent; all other behaviour identical.

Test Plan:
- Basic update:
  - Stimulus: x=1..12, v all 10, y=12..1, u=1..4, z all 5, g=6,5,4,3; pulse start.
  - Required: y_next = 3,3,3,...,3 (all 3); g_next = 2,2,2,2; done pulses once, exactly 16 edges after the capture edge; busy high throughout.
- Saturation:
  - Stimulus: y[0]=32767, x[0]=100, v[0]=0; y[1]=-32768, x[1]=-5, v[1]=10; g[0]=32000, u[0]=1000, z[0]=-1000.
  - Required: y_next[0]=32767; y_next[1]=-32768; g_next[0]=32767.
- Input snapshot and ignored start:
  - Stimulus: change all inputs to 0 and pulse start again 3 cycles after the first start.
  - Required: results still reflect the first captured inputs; exactly one done pulse.
- Reset mid-job:
  - Stimulus: drop reset at cycle 7 of a job, release it, then issue a new start.
  - Required: outputs 0 immediately, busy=0, no done for the aborted job; the new job completes normally with correct values.
- Back-to-back:
  - Stimulus: hold start=1 continuously.
  - Required: jobs recur every STATE_DIM+CONTROL_DIM+2 = 18 cycles; done is never high on consecutive cycles.
- With DUAL_RESIDUAL_EN:
  - Stimulus: basic-update vectors, except x[11]=-20.
  - Required: primal_res = 30 while done=1; y_next[11] = 1 + (-20) - 10 = -29.
